// File: rtl/sa_cache_nway.sv
// N-way set-associative, write-back / write-allocate cache with one DATA_W word per line.
// Replacement is true LRU, tracked as a per-way age permutation inside each set.
module sa_cache_nway #(
  parameter int WAYS     = 4,
  parameter int INDEX_W  = 8,
  parameter int TAG_W    = 18,
  parameter int OFFSET_W = 6,
  parameter int DATA_W   = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [TAG_W-1:0]              i_tag,
  input  logic [INDEX_W-1:0]            i_index,
  input  logic [OFFSET_W-1:0]           i_offset,
  input  logic                          memRW,
  input  logic [DATA_W-1:0]             dataW,
  output logic                          resp_valid,
  output logic [DATA_W-1:0]             o_data_out,
  output logic                          cache_miss,
  output logic                          mem_req_valid,
  output logic                          mem_req_we,
  output logic [TAG_W+INDEX_W+OFFSET_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0]             mem_req_data,
  input  logic                          mem_resp_valid,
  input  logic [DATA_W-1:0]             i_memory_line
);

  localparam int SETS  = 1 << INDEX_W;
  localparam int AGE_W = $clog2(WAYS);

  typedef enum logic [2:0] {IDLE, LOOKUP, EVICT, FILL, RESP} state_t;

  state_t state;

  logic              valid_q [SETS][WAYS];
  logic              dirty_q [SETS][WAYS];
  logic [TAG_W-1:0]  tag_q   [SETS][WAYS];
  logic [DATA_W-1:0] data_q  [SETS][WAYS];
  logic [AGE_W-1:0]  age_q   [SETS][WAYS];

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_index;
  logic [OFFSET_W-1:0] req_offset;
  logic                req_rw;
  logic [DATA_W-1:0]   req_wdata;
  logic [AGE_W-1:0]    vic_way;

  logic              hit;
  logic [AGE_W-1:0]  hit_way;
  logic [AGE_W-1:0]  victim_way;
  logic              victim_dirty;
  logic              lookup_hit;
  logic              fill_done;
  logic [DATA_W-1:0] fill_data;
  logic              touch_en;
  logic [AGE_W-1:0]  touch_way;
  logic [AGE_W-1:0]  prior_age;
  logic              arr_we;
  logic [DATA_W-1:0] arr_data;
  logic              unused_offset;

  // The offset travels with the request but never takes part in lookup.
  assign unused_offset = ^req_offset;

  // Descending scans so the lowest-numbered matching way wins; an invalid way beats the LRU way.
  always_comb begin
    hit        = 1'b0;
    hit_way    = '0;
    victim_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[req_index][AGE_W'(w)] && (tag_q[req_index][AGE_W'(w)] == req_tag)) begin
        hit     = 1'b1;
        hit_way = AGE_W'(w);
      end
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (age_q[req_index][AGE_W'(w)] == AGE_W'(WAYS - 1)) victim_way = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[req_index][AGE_W'(w)]) victim_way = AGE_W'(w);
    end
  end

  assign victim_dirty = valid_q[req_index][victim_way] && dirty_q[req_index][victim_way];
  assign lookup_hit   = (state == LOOKUP) && hit;
  assign fill_done    = (state == FILL) && mem_req_valid && mem_resp_valid;
  assign fill_data    = req_rw ? req_wdata : i_memory_line;
  assign touch_en     = lookup_hit || fill_done;
  assign touch_way    = (state == LOOKUP) ? hit_way : vic_way;
  assign prior_age    = age_q[req_index][touch_way];
  assign arr_we       = (lookup_hit && req_rw) || fill_done;
  assign arr_data     = (state == LOOKUP) ? req_wdata : fill_data;

  // Tag and data storage carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (arr_we) data_q[req_index][touch_way] <= arr_data;
    if (fill_done) tag_q[req_index][vic_way] <= req_tag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b1;
      resp_valid    <= 1'b0;
      cache_miss    <= 1'b0;
      o_data_out    <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_data  <= '0;
      req_tag       <= '0;
      req_index     <= '0;
      req_offset    <= '0;
      req_rw        <= 1'b0;
      req_wdata     <= '0;
      vic_way       <= '0;
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          valid_q[INDEX_W'(s)][AGE_W'(w)] <= 1'b0;
          dirty_q[INDEX_W'(s)][AGE_W'(w)] <= 1'b0;
          age_q[INDEX_W'(s)][AGE_W'(w)]   <= AGE_W'(w);
        end
      end
    end else begin
      // Accessed way becomes youngest; only ways younger than it age by one.
      if (touch_en) begin
        for (int w = 0; w < WAYS; w++) begin
          if (AGE_W'(w) == touch_way)
            age_q[req_index][AGE_W'(w)] <= '0;
          else if (age_q[req_index][AGE_W'(w)] < prior_age)
            age_q[req_index][AGE_W'(w)] <= age_q[req_index][AGE_W'(w)] + AGE_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (req_valid) begin
            req_tag    <= i_tag;
            req_index  <= i_index;
            req_offset <= i_offset;
            req_rw     <= memRW;
            req_wdata  <= dataW;
            req_ready  <= 1'b0;
            state      <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (req_rw) dirty_q[req_index][hit_way] <= 1'b1;
            o_data_out <= req_rw ? req_wdata : data_q[req_index][hit_way];
            cache_miss <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            vic_way       <= victim_way;
            mem_req_valid <= 1'b1;
            if (victim_dirty) begin
              mem_req_we   <= 1'b1;
              mem_req_addr <= {tag_q[req_index][victim_way], req_index, {OFFSET_W{1'b0}}};
              mem_req_data <= data_q[req_index][victim_way];
              state        <= EVICT;
            end else begin
              mem_req_we   <= 1'b0;
              mem_req_addr <= {req_tag, req_index, {OFFSET_W{1'b0}}};
              state        <= FILL;
            end
          end
        end
        EVICT: begin
          if (mem_resp_valid) begin
            mem_req_valid <= 1'b0;
            state         <= FILL;
          end
        end
        FILL: begin
          // After a writeback the fill is issued one cycle later as a fresh request.
          if (!mem_req_valid) begin
            mem_req_valid <= 1'b1;
            mem_req_we    <= 1'b0;
            mem_req_addr  <= {req_tag, req_index, {OFFSET_W{1'b0}}};
          end else if (mem_resp_valid) begin
            mem_req_valid                <= 1'b0;
            valid_q[req_index][vic_way]  <= 1'b1;
            dirty_q[req_index][vic_way]  <= req_rw;
            o_data_out                   <= fill_data;
            cache_miss                   <= 1'b1;
            resp_valid                   <= 1'b1;
            state                        <= RESP;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sa_cache_nway.sv
// Randomized bench for sa_cache_nway against a recency-list cache model and a
// behavioural backing memory that serves fills and absorbs writebacks.
module tb_sa_cache_nway;

  localparam int WAYS     = 4;
  localparam int INDEX_W  = 8;
  localparam int TAG_W    = 18;
  localparam int OFFSET_W = 6;
  localparam int DATA_W   = 32;
  localparam int SETS     = 1 << INDEX_W;
  localparam int AW       = TAG_W + INDEX_W + OFFSET_W;

  typedef struct packed {
    logic              we;
    logic [AW-1:0]     addr;
    logic [DATA_W-1:0] data;
  } memtxn_t;

  logic                clk;
  logic                rst_n;
  logic                req_valid;
  logic                req_ready;
  logic [TAG_W-1:0]    i_tag;
  logic [INDEX_W-1:0]  i_index;
  logic [OFFSET_W-1:0] i_offset;
  logic                memRW;
  logic [DATA_W-1:0]   dataW;
  logic                resp_valid;
  logic [DATA_W-1:0]   o_data_out;
  logic                cache_miss;
  logic                mem_req_valid;
  logic                mem_req_we;
  logic [AW-1:0]       mem_req_addr;
  logic [DATA_W-1:0]   mem_req_data;
  logic                mem_resp_valid;
  logic [DATA_W-1:0]   i_memory_line;

  int compared   = 0;
  int mismatched = 0;

  bit              m_valid [SETS][WAYS];
  bit              m_dirty [SETS][WAYS];
  logic [TAG_W-1:0]  m_tag [SETS][WAYS];
  logic [DATA_W-1:0] m_data [SETS][WAYS];
  int              m_order [SETS][$];
  logic [DATA_W-1:0] ref_mem  [logic [AW-1:0]];
  logic [DATA_W-1:0] phys_mem [logic [AW-1:0]];
  memtxn_t         mem_log [$];
  memtxn_t         exp_q [$];
  bit              mem_hold;
  int              hold_len;

  sa_cache_nway #(
    .WAYS(WAYS), .INDEX_W(INDEX_W), .TAG_W(TAG_W), .OFFSET_W(OFFSET_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .i_tag(i_tag), .i_index(i_index), .i_offset(i_offset), .memRW(memRW), .dataW(dataW),
    .resp_valid(resp_valid), .o_data_out(o_data_out), .cache_miss(cache_miss),
    .mem_req_valid(mem_req_valid), .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid), .i_memory_line(i_memory_line)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DATA_W-1:0] fill_val(input logic [AW-1:0] a);
    return DATA_W'(a * 32'h9E37_79B1) ^ DATA_W'(32'h5A5A_0F0F);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) begin
      m_order[s].delete();
      for (int w = 0; w < WAYS; w++) begin
        m_valid[s][w] = 1'b0;
        m_dirty[s][w] = 1'b0;
        m_order[s].push_back(w);
      end
    end
  endfunction

  // Most recently used way sits at the front of the list, LRU at the back.
  function automatic void touch(input int s, input int w);
    for (int k = 0; k < m_order[s].size(); k++) begin
      if (m_order[s][k] == w) begin
        m_order[s].delete(k);
        break;
      end
    end
    m_order[s].push_front(w);
  endfunction

  function automatic void model_access(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] ix,
                                       input bit rw, input logic [DATA_W-1:0] wd,
                                       output bit miss, output logic [DATA_W-1:0] rdata);
    int s;
    int way;
    logic [AW-1:0] a;
    s   = int'(ix);
    way = -1;
    exp_q.delete();
    for (int w = 0; w < WAYS; w++)
      if (m_valid[s][w] && m_tag[s][w] == t) way = w;
    if (way >= 0) begin
      miss = 1'b0;
      if (rw) begin
        m_data[s][way]  = wd;
        m_dirty[s][way] = 1'b1;
      end
    end else begin
      miss = 1'b1;
      for (int w = WAYS - 1; w >= 0; w--)
        if (!m_valid[s][w]) way = w;
      if (way < 0) way = m_order[s][WAYS-1];
      if (m_valid[s][way] && m_dirty[s][way]) begin
        a = {m_tag[s][way], ix, OFFSET_W'(0)};
        ref_mem[a] = m_data[s][way];
        exp_q.push_back('{we: 1'b1, addr: a, data: m_data[s][way]});
      end
      a = {t, ix, OFFSET_W'(0)};
      exp_q.push_back('{we: 1'b0, addr: a, data: '0});
      m_data[s][way]  = rw ? wd : (ref_mem.exists(a) ? ref_mem[a] : fill_val(a));
      m_valid[s][way] = 1'b1;
      m_dirty[s][way] = rw;
      m_tag[s][way]   = t;
    end
    rdata = m_data[s][way];
    touch(s, way);
  endfunction

  // Backing memory: answers each request after a random (or forced) delay.
  initial begin
    memtxn_t cur;
    int n;
    bit ok;
    mem_resp_valid = 1'b0;
    i_memory_line  = '0;
    forever begin
      @(negedge clk);
      if (rst_n && mem_req_valid) begin
        cur = '{we: mem_req_we, addr: mem_req_addr, data: mem_req_data};
        n   = mem_hold ? hold_len : $urandom_range(0, 3);
        ok  = 1'b1;
        for (int i = 0; i < n; i++) begin
          @(negedge clk);
          if (!mem_req_valid) begin
            ok = 1'b0;
            break;
          end
          if (mem_hold) begin
            checkOutput("mem_req_stable", 96'({mem_req_we, mem_req_addr, mem_req_data}), 96'(cur));
            checkOutput("req_ready_busy", 96'(req_ready), 96'(0));
          end
        end
        if (ok) begin
          mem_log.push_back(cur);
          if (cur.we) begin
            phys_mem[cur.addr] = cur.data;
            i_memory_line = DATA_W'($urandom);
          end else begin
            i_memory_line = phys_mem.exists(cur.addr) ? phys_mem[cur.addr] : fill_val(cur.addr);
          end
          mem_resp_valid = 1'b1;
          @(posedge clk);
          #1;
          mem_resp_valid = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic [TAG_W-1:0] t, input logic [INDEX_W-1:0] ix,
                               input bit rw, input logic [DATA_W-1:0] wd);
    bit exp_miss;
    logic [DATA_W-1:0] exp_data;
    int cnt;
    bit got;
    model_access(t, ix, rw, wd, exp_miss, exp_data);
    mem_log.delete();
    cnt = 0;
    while (!req_ready && cnt < 50) begin
      @(negedge clk);
      cnt++;
    end
    checkOutput("req_ready_idle", 96'(req_ready), 96'(1));
    req_valid = 1'b1;
    i_tag     = t;
    i_index   = ix;
    i_offset  = OFFSET_W'($urandom);
    memRW     = rw;
    dataW     = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    i_tag     = TAG_W'($urandom);
    i_index   = INDEX_W'($urandom);
    memRW     = 1'($urandom);
    dataW     = DATA_W'($urandom);
    got = 1'b0;
    for (cnt = 1; cnt <= 400; cnt++) begin
      @(negedge clk);
      if (resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("resp_seen", 96'(got), 96'(1));
    if (got) begin
      checkOutput("cache_miss", 96'(cache_miss), 96'(exp_miss));
      checkOutput("data_out", 96'(o_data_out), 96'(exp_data));
      if (!exp_miss) checkOutput("hit_latency", 96'(cnt), 96'(2));
      @(negedge clk);
      checkOutput("resp_one_cycle", 96'(resp_valid), 96'(0));
      checkOutput("req_ready_after", 96'(req_ready), 96'(1));
    end
    checkOutput("mem_txn_count", 96'(mem_log.size()), 96'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < mem_log.size(); k++) begin
      checkOutput("mem_we", 96'(mem_log[k].we), 96'(exp_q[k].we));
      checkOutput("mem_addr", 96'(mem_log[k].addr), 96'(exp_q[k].addr));
      if (exp_q[k].we) checkOutput("wb_data", 96'(mem_log[k].data), 96'(exp_q[k].data));
    end
  endtask

  task automatic checkResetOutputs();
    checkOutput("rst_req_ready", 96'(req_ready), 96'(1));
    checkOutput("rst_resp_valid", 96'(resp_valid), 96'(0));
    checkOutput("rst_cache_miss", 96'(cache_miss), 96'(0));
    checkOutput("rst_mem_req_valid", 96'(mem_req_valid), 96'(0));
    checkOutput("rst_mem_req_we", 96'(mem_req_we), 96'(0));
    checkOutput("rst_o_data_out", 96'(o_data_out), 96'(0));
    checkOutput("rst_mem_req_addr", 96'(mem_req_addr), 96'(0));
    checkOutput("rst_mem_req_data", 96'(mem_req_data), 96'(0));
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [AW-1:0] a;
    bit got;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    i_tag     = '0;
    i_index   = '0;
    i_offset  = '0;
    memRW     = 1'b0;
    dataW     = '0;
    mem_hold  = 1'b0;
    hold_len  = 0;
    model_reset();
    a = {TAG_W'(3), INDEX_W'(8'h10), OFFSET_W'(0)};
    phys_mem[a] = 32'hDEAD_BEEF;
    ref_mem[a]  = 32'hDEAD_BEEF;

    repeat (2) @(negedge clk);
    checkResetOutputs();
    rst_n = 1'b1;
    @(negedge clk);

    // Cold miss then hit on the same line.
    applyStimulus(TAG_W'(3), INDEX_W'(8'h10), 1'b0, '0);
    checkOutput("cold_fill_data", 96'(o_data_out), 96'(32'hDEAD_BEEF));
    applyStimulus(TAG_W'(3), INDEX_W'(8'h10), 1'b0, '0);

    // Write hit followed by read back without memory traffic.
    applyStimulus(TAG_W'(3), INDEX_W'(8'h10), 1'b1, 32'h1234_5678);
    applyStimulus(TAG_W'(3), INDEX_W'(8'h10), 1'b0, '0);
    checkOutput("write_hit_readback", 96'(o_data_out), 96'(32'h1234_5678));

    // LRU victim selection in a full set.
    for (int t = 1; t <= 4; t++) applyStimulus(TAG_W'(t), INDEX_W'(5), 1'b0, '0);
    applyStimulus(TAG_W'(1), INDEX_W'(5), 1'b0, '0);
    applyStimulus(TAG_W'(5), INDEX_W'(5), 1'b0, '0);
    applyStimulus(TAG_W'(1), INDEX_W'(5), 1'b0, '0);
    applyStimulus(TAG_W'(2), INDEX_W'(5), 1'b0, '0);

    // Dirty line is written back before the conflicting fill.
    applyStimulus(TAG_W'(1), INDEX_W'(7), 1'b1, 32'hCAFE_0001);
    for (int t = 2; t <= 5; t++) applyStimulus(TAG_W'(t), INDEX_W'(7), 1'b0, '0);

    // Memory stalls for 20 cycles during a fill.
    mem_hold = 1'b1;
    hold_len = 20;
    applyStimulus(TAG_W'(9), INDEX_W'(7), 1'b0, '0);
    mem_hold = 1'b0;

    for (int i = 0; i < 300; i++)
      applyStimulus(TAG_W'($urandom_range(0, 7)), INDEX_W'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), DATA_W'($urandom));

    // Reset asserted in the middle of an outstanding fill.
    applyStimulus(TAG_W'(8'h11), INDEX_W'(8'h20), 1'b0, '0);
    mem_hold  = 1'b1;
    hold_len  = 1000;
    req_valid = 1'b1;
    i_tag     = TAG_W'(8'h22);
    i_index   = INDEX_W'(8'h20);
    memRW     = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_req_valid) begin
        got = 1'b1;
        break;
      end
    end
    checkOutput("fill_issued", 96'(got), 96'(1));
    checkOutput("fill_addr", 96'(mem_req_addr), 96'({TAG_W'(8'h22), INDEX_W'(8'h20), OFFSET_W'(0)}));
    #2;
    rst_n = 1'b0;
    #1;
    checkResetOutputs();
    @(negedge clk);
    @(negedge clk);
    rst_n    = 1'b1;
    mem_hold = 1'b0;
    model_reset();
    @(negedge clk);
    applyStimulus(TAG_W'(8'h11), INDEX_W'(8'h20), 1'b0, '0);
    checkOutput("miss_after_reset", 96'(cache_miss), 96'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/sa_cache_nway.md
SA_CACHE_NWAY -- requirements
Module: sa_cache_nway

Interface
REQ-001 SHALL have parameter WAYS, default 4, associativity; power of two, 2..8.
REQ-002 SHALL have parameter INDEX_W, default 8, set-index width; sets = 2^INDEX_W.
REQ-003 SHALL have parameter TAG_W, default 18, tag width.
REQ-004 SHALL have parameter OFFSET_W, default 6, byte-offset width; forwarded only, not used in lookup.
REQ-005 SHALL have parameter DATA_W, default 32, line width; one line = one DATA_W word.
REQ-006 Ports, clock and reset first:
  clk  in  1  sole clock, rising edge
  rst_n  in  1  asynchronous, active-low reset
  req_valid  in  1  request present
  req_ready  out  1  request accepted when req_valid&req_ready at clk edge
  i_tag  in  TAG_W  request tag
  i_index  in  INDEX_W  request set index
  i_offset  in  OFFSET_W  request offset
  memRW  in  1  1=write, 0=read
  dataW  in  DATA_W  write data
  resp_valid  out  1  one-cycle response strobe
  o_data_out  out  DATA_W  read data (write: data written)
  cache_miss  out  1  valid with resp_valid; 1=request missed
  mem_req_valid  out  1  backing-memory request, held until mem_resp_valid
  mem_req_we  out  1  1=writeback, 0=fill
  mem_req_addr  out  TAG_W+INDEX_W+OFFSET_W  {tag,index,offset=0}
  mem_req_data  out  DATA_W  writeback data
  mem_resp_valid  in  1  memory ack / fill data valid, one cycle
  i_memory_line  in  DATA_W  fill data, sampled with mem_resp_valid

Function
REQ-007 SHALL be write-back, write-allocate; per way per set: valid, dirty, tag, data, age (log2(WAYS) bits).
REQ-008 FSM states: IDLE, LOOKUP, EVICT, FILL, RESP; req_ready=1 only in IDLE.
REQ-009 IDLE: on accept, register tag/index/offset/memRW/dataW, go LOOKUP.
REQ-010 LOOKUP: hit = valid & tag match in exactly one way; hit -> RESP, read returns stored line, write stores dataW and sets dirty.
REQ-011 Hit latency: resp_valid high exactly 2 cycles after accepting edge; cache_miss=0.
REQ-012 Miss victim: lowest-index invalid way; if none, way with age = WAYS-1 (LRU).
REQ-013 Miss, victim valid & dirty -> EVICT; else -> FILL.
REQ-014 EVICT: mem_req_valid=1, we=1, addr={victim tag,index,0}, data=victim line; on mem_resp_valid -> FILL.
REQ-015 FILL: mem_req_valid=1, we=0, addr={req tag,index,0}; on mem_resp_valid write i_memory_line (write request: dataW instead), set valid, tag, dirty=memRW, -> RESP.
REQ-016 mem_req_* SHALL stay stable while mem_req_valid=1; mem_req_valid drops cycle after mem_resp_valid.
REQ-017 RESP: resp_valid=1 one cycle, cache_miss set if LOOKUP missed, o_data_out valid; then IDLE.
REQ-018 LRU update on every hit and fill: accessed way age=0; ways with age less than accessed way's prior age +1; others unchanged; ages stay a permutation of 0..WAYS-1.
REQ-019 mem_resp_valid outside EVICT/FILL SHALL be ignored; req_valid outside IDLE ignored (no queuing).
REQ-020 Back-to-back: new request accepted in IDLE cycle following RESP; no combinational path req_valid->req_ready.

Reset
REQ-021 rst_n low SHALL asynchronously force IDLE, all valid/dirty=0, age[w]=w in every set, outputs req_ready=1, resp_valid=0, cache_miss=0, mem_req_valid=0, mem_req_we=0, o_data_out=0, mem_req_addr=0, mem_req_data=0.
REQ-022 Reset during EVICT/FILL SHALL abandon transaction; no array update, no response.
REQ-023 Data and tag arrays need not be reset.

Verification
REQ-024 Cold read tag=0x3,index=0x10 -> miss, FILL addr={0x3,0x10,0}, memory returns 0xDEADBEEF -> resp cache_miss=1, data 0xDEADBEEF; repeat -> hit, 2-cycle latency, data 0xDEADBEEF.
REQ-025 Write hit dataW=0x12345678 to filled line, then read -> cache_miss=0, data 0x12345678, no memory traffic.
REQ-026 Fill 4 tags 1..4 at index 5, read tag 1, access tag 5 -> victim tag 2 (LRU); read tag 1 still hits.
REQ-027 Write tag 1 index 7, fill tags 2..5 index 7 -> EVICT we=1 addr={1,7,0} data=written value precedes FILL of tag 5.
REQ-028 Assert rst_n low mid-FILL -> outputs at reset values immediately; prior-filled line then misses.
REQ-029 Hold mem_resp_valid low 20 cycles in FILL -> mem_req_* stable, req_ready=0 throughout.
